// File: rtl/memory_cycle.sv
// Memory-stage data memory with byte/half/word stores, extended loads and the M/W pipeline register.
// Optional macro MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into suppressed, sticky-flagged ops.
module memory_cycle #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [1:0]  MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RDM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUResultW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RDW,
    output logic        MisalignW
);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] word_idx;
    logic [1:0]    byte_off;
    logic [31:0]   rd_word;
    logic [31:0]   wr_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;
    logic          misalign;
    logic          store_en;

    assign word_idx = ALUResultM[AW+1:2];
    assign byte_off = ALUResultM[1:0];
    // Read is asynchronous, so a store and load on the same op see the pre-store word.
    assign rd_word  = mem[word_idx];
    assign rd_byte  = rd_word[{byte_off, 3'b000} +: 8];
    assign rd_half  = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

`ifdef MEM_MISALIGN_TRAP_EN
    logic half_access;
    logic word_access;
    logic misalign_q;

    assign half_access = (MemWriteM == 2'b10) || (RegWriteM == 3'b011) || (RegWriteM == 3'b101);
    // A word load is class 001/110/111 reading memory; plain ALU writebacks never trap.
    assign word_access = (MemWriteM == 2'b11) ||
                         ((ResultSrcM == 2'b01) &&
                          ((RegWriteM == 3'b001) || (RegWriteM == 3'b110) || (RegWriteM == 3'b111)));
    assign misalign    = (half_access && byte_off[0]) || (word_access && (byte_off != 2'b00));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else if (misalign) begin
            misalign_q <= 1'b1;
        end
    end

    assign MisalignW = misalign_q;
`else
    assign misalign  = 1'b0;
    assign MisalignW = 1'b0;
`endif

    assign store_en = (MemWriteM != 2'b00) && !misalign;

    always_comb begin
        wr_word = rd_word;
        case (MemWriteM)
            2'b01: wr_word[{byte_off, 3'b000} +: 8] = WriteDataM[7:0];
            2'b10: begin
                if (byte_off[1]) begin
                    wr_word[31:16] = WriteDataM[15:0];
                end else begin
                    wr_word[15:0] = WriteDataM[15:0];
                end
            end
            2'b11: wr_word = WriteDataM;
            default: wr_word = rd_word;
        endcase
    end

    always_comb begin
        case (RegWriteM)
            3'b010:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b011:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_data = {24'h0, rd_byte};
            3'b101:  load_data = {16'h0, rd_half};
            default: load_data = rd_word;
        endcase
    end

    // Memory contents are not reset; writes are only blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst && store_en) begin
            mem[word_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ReadDataW  <= 32'h0;
            ALUResultW <= 32'h0;
            PCPlus4W   <= 32'h0;
            RDW        <= 5'h0;
        end else begin
            RegWriteW  <= (RegWriteM != 3'b000) && !misalign;
            ResultSrcW <= ResultSrcM;
            ReadDataW  <= load_data;
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            RDW        <= RDM;
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: stores, extended loads, wrap, store/load overlap, reset and misalignment.
module tb_memory_cycle;

    logic        clk;
    logic        rst;
    logic [2:0]  RegWriteM;
    logic [1:0]  ResultSrcM;
    logic [1:0]  MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic [4:0]  RDM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ReadDataW;
    logic [31:0] ALUResultW;
    logic [31:0] PCPlus4W;
    logic [4:0]  RDW;
    logic        MisalignW;

    int checks = 0;
    int errors = 0;

    memory_cycle #(.DEPTH_WORDS(1024), .AW(10)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RDM(RDM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .ReadDataW(ReadDataW),
        .ALUResultW(ALUResultW), .PCPlus4W(PCPlus4W), .RDW(RDW), .MisalignW(MisalignW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [2:0] rw, input logic [1:0] rs, input logic [1:0] mw,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] pc, input logic [4:0] rd);
        RegWriteM  = rw;
        ResultSrcM = rs;
        MemWriteM  = mw;
        ALUResultM = addr;
        WriteDataM = wd;
        PCPlus4M   = pc;
        RDM        = rd;
    endtask

    // Apply one op and return 1 time unit after the capturing edge.
    task automatic op(input logic [2:0] rw, input logic [1:0] rs, input logic [1:0] mw,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] pc, input logic [4:0] rd);
        set_in(rw, rs, mw, addr, wd, pc, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic sw(input logic [31:0] addr, input logic [31:0] wd);
        op(3'b000, 2'b00, 2'b11, addr, wd, 32'h0, 5'd0);
    endtask

    task automatic ld(input logic [2:0] cls, input logic [31:0] addr);
        op(cls, 2'b01, 2'b00, addr, 32'h0, 32'h0, 5'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_regwrite"},  {31'h0, RegWriteW}, 32'h0);
        chk({tag, "_resultsrc"}, {30'h0, ResultSrcW}, 32'h0);
        chk({tag, "_readdata"},  ReadDataW, 32'h0);
        chk({tag, "_aluresult"}, ALUResultW, 32'h0);
        chk({tag, "_pcplus4"},   PCPlus4W, 32'h0);
        chk({tag, "_rd"},        {27'h0, RDW}, 32'h0);
        chk({tag, "_misalign"},  {31'h0, MisalignW}, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        set_in(3'b000, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b1;

        sw(32'h010, 32'h0);
        sw(32'h020, 32'h0);
        sw(32'h040, 32'h0);

        sw(32'h010, 32'hDEADBEEF);
        chk("sw_regwrite", {31'h0, RegWriteW}, 32'h0);
        op(3'b001, 2'b01, 2'b00, 32'h010, 32'h0, 32'h104, 5'd5);
        chk("lw_data", ReadDataW, 32'hDEADBEEF);
        chk("lw_regwrite", {31'h0, RegWriteW}, 32'h1);
        chk("lw_resultsrc", {30'h0, ResultSrcW}, 32'h1);
        chk("lw_rd", {27'h0, RDW}, 32'd5);
        chk("lw_pcplus4", PCPlus4W, 32'h104);
        chk("lw_aluresult", ALUResultW, 32'h010);

        op(3'b001, 2'b10, 2'b00, 32'h0000_0ABC, 32'h0, 32'h0, 5'd9);
        chk("link_resultsrc", {30'h0, ResultSrcW}, 32'h2);
        chk("link_aluresult", ALUResultW, 32'h0000_0ABC);

        sw(32'h010, 32'h0);
        op(3'b000, 2'b00, 2'b01, 32'h013, 32'h0000_0080, 32'h0, 5'd0);
        ld(3'b010, 32'h013);
        chk("lb_sext", ReadDataW, 32'hFFFFFF80);
        ld(3'b100, 32'h013);
        chk("lbu_zext", ReadDataW, 32'h00000080);
        ld(3'b001, 32'h010);
        chk("sb_word", ReadDataW, 32'h80000000);
        ld(3'b010, 32'h012);
        chk("lb_other_lane", ReadDataW, 32'h0);

        op(3'b000, 2'b00, 2'b10, 32'h022, 32'h0000_1234, 32'h0, 5'd0);
        ld(3'b011, 32'h022);
        chk("lh_upper", ReadDataW, 32'h00001234);
        op(3'b000, 2'b00, 2'b10, 32'h020, 32'hFFFF_8001, 32'h0, 5'd0);
        ld(3'b101, 32'h020);
        chk("lhu_lower", ReadDataW, 32'h00008001);
        ld(3'b011, 32'h020);
        chk("lh_lower", ReadDataW, 32'hFFFF8001);
        ld(3'b001, 32'h020);
        chk("sh_merge", ReadDataW, 32'h12348001);

        sw(32'h1004, 32'h11111111);
        ld(3'b001, 32'h004);
        chk("wrap", ReadDataW, 32'h11111111);

        sw(32'h050, 32'h01020304);
        op(3'b001, 2'b01, 2'b11, 32'h050, 32'hAAAA5555, 32'h0, 5'd3);
        chk("st_ld_prestore", ReadDataW, 32'h01020304);
        ld(3'b001, 32'h050);
        chk("st_ld_after", ReadDataW, 32'hAAAA5555);

        sw(32'h030, 32'hCAFEF00D);
        chk("pre_rst_alu", ALUResultW, 32'h030);
        set_in(3'b001, 2'b01, 2'b11, 32'h030, 32'h99999999, 32'h44, 5'd6);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        chk_all_zero("held_rst");
        rst = 1'b1;
        op(3'b001, 2'b01, 2'b00, 32'h030, 32'h0, 32'h200, 5'd7);
        chk("rst_no_write", ReadDataW, 32'hCAFEF00D);
        chk("rst_release_regwrite", {31'h0, RegWriteW}, 32'h1);
        chk("rst_release_rd", {27'h0, RDW}, 32'd7);

        op(3'b001, 2'b00, 2'b11, 32'h041, 32'h5A5A5A5A, 32'h0, 5'd2);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_regwrite", {31'h0, RegWriteW}, 32'h0);
        chk("mis_flag", {31'h0, MisalignW}, 32'h1);
        ld(3'b001, 32'h040);
        chk("mis_no_write", ReadDataW, 32'h0);
        chk("mis_sticky", {31'h0, MisalignW}, 32'h1);
`else
        chk("mis_regwrite", {31'h0, RegWriteW}, 32'h1);
        chk("mis_flag", {31'h0, MisalignW}, 32'h0);
        ld(3'b001, 32'h040);
        chk("mis_write", ReadDataW, 32'h5A5A5A5A);
        chk("mis_flag_after", {31'h0, MisalignW}, 32'h0);
`endif
        rst = 1'b0;
        #1;
        chk("final_rst_misalign", {31'h0, MisalignW}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
